// File: rtl/sram_pin_responder.sv
// Pin-level asynchronous-SRAM emulator: registers the controller's pins, decodes
// write/read commands against an internal array and returns read data READ_LAT cycles later.
module sram_pin_responder #(
  parameter int ADDRW      = 19,
  parameter int DATAW      = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_LAT   = 2
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             SRAM_CS_Pin,
  input  logic             SRAM_WR_Pin,
  input  logic             SRAM_OE_Pin,
  input  logic [ADDRW-1:0] SRAM_ADDR_Pin,
  input  logic [DATAW-1:0] SRAM_DATA_IN_Pin,
  output logic [DATAW-1:0] SRAM_DATA_OUT_Pin,
  output logic             SRAM_DATA_OE,
  input  logic             clr_flags,
  output logic [15:0]      wr_count,
  output logic [15:0]      rd_count,
  output logic             conflict_flag,
  output logic             addr_err_flag
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Registered pin image; reset parks it in the deselected state so no
  // command is decoded on the first edge after reset.
  logic             s_cs;
  logic             s_wr;
  logic             s_oe;
  logic [ADDRW-1:0] s_addr;
  logic [DATAW-1:0] s_data;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      s_cs   <= 1'b1;
      s_wr   <= 1'b1;
      s_oe   <= 1'b1;
      s_addr <= '0;
      s_data <= '0;
    end else begin
      s_cs   <= SRAM_CS_Pin;
      s_wr   <= SRAM_WR_Pin;
      s_oe   <= SRAM_OE_Pin;
      s_addr <= SRAM_ADDR_Pin;
      s_data <= SRAM_DATA_IN_Pin;
    end
  end

  logic                  wr_cmd;
  logic                  rd_cmd;
  logic                  conflict_cmd;
  logic                  addr_ok;
  logic                  wr_hit;
  logic                  addr_err;
  logic [DEPTH_LOG2-1:0] idx;

  // WR low wins over OE low: contention is a write, never a read.
  always_comb begin
    wr_cmd       = 1'b0;
    rd_cmd       = 1'b0;
    conflict_cmd = 1'b0;
    if (!s_cs) begin
      wr_cmd       = !s_wr;
      rd_cmd       = s_wr && !s_oe;
      conflict_cmd = !s_wr && !s_oe;
    end
  end

  assign addr_ok  = (s_addr >> DEPTH_LOG2) == '0;
  assign idx      = s_addr[DEPTH_LOG2-1:0];
  assign wr_hit   = wr_cmd && addr_ok;
  assign addr_err = (wr_cmd || rd_cmd) && !addr_ok;

  logic [DATAW-1:0] mem [DEPTH];
  logic [DATAW-1:0] pipe_data [READ_LAT];
  logic [READ_LAT-1:0] pipe_vld;

  // Array and data pipeline carry no reset: contents survive reset and only
  // the valid bits decide what reaches the pins.
  always_ff @(posedge CLK) begin
    if (RSTn && wr_hit) begin
      mem[idx] <= s_data;
    end
    pipe_data[0] <= addr_ok ? mem[idx] : '0;
    for (int i = 1; i < READ_LAT; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  // SRAM_DATA_OE is a one-cycle valid qualifier per read command with no
  // back-pressure: the controller must take SRAM_DATA_OUT_Pin in that cycle.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      pipe_vld          <= '0;
      SRAM_DATA_OE      <= 1'b0;
      SRAM_DATA_OUT_Pin <= '0;
    end else begin
      pipe_vld[0] <= rd_cmd;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
      SRAM_DATA_OE <= pipe_vld[READ_LAT-1];
      if (pipe_vld[READ_LAT-1]) begin
        SRAM_DATA_OUT_Pin <= pipe_data[READ_LAT-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn || clr_flags) begin
      wr_count      <= '0;
      rd_count      <= '0;
      conflict_flag <= 1'b0;
      addr_err_flag <= 1'b0;
    end else begin
      if (wr_hit && wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'd1;
      end
      if (rd_cmd && rd_count != 16'hFFFF) begin
        rd_count <= rd_count + 16'd1;
      end
      if (conflict_cmd) begin
        conflict_flag <= 1'b1;
      end
      if (addr_err) begin
        addr_err_flag <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sram_pin_responder.md
Name: sram_pin_responder

Overview:
- Synthesizable SRAM-device emulator. It sits on the pin side of the SRAM controller and answers its CS/WR/OE/ADDR/DATA pin traffic the way an external asynchronous SRAM chip would.
- Backed by an internal register/BRAM array. Used for on-FPGA loopback of the SRAM init/lookup path without the external part.
- Adds command counters and sticky protocol-error flags for debug.

Parameters:
ADDRW, 19, width of the address pin bus.
DATAW, 32, width of the data pin bus.
DEPTH_LOG2, 10, implemented words = 2^DEPTH_LOG2; must be ≤ ADDRW.
READ_LAT, 2, cycles from sampled read command to valid output data; legal range 1..4.

Ports:
CLK  input  1  single system clock; all logic on rising edge.
RSTn  input  1  reset, synchronous, active-low.
SRAM_CS_Pin  input  1  chip select, active-low.
SRAM_WR_Pin  input  1  write strobe, active-low.
SRAM_OE_Pin  input  1  output enable, active-low.
SRAM_ADDR_Pin  input  ADDRW  word address.
SRAM_DATA_IN_Pin  input  DATAW  write data driven by the controller.
SRAM_DATA_OUT_Pin  output  DATAW  read data returned to the controller.
SRAM_DATA_OE  output  1  high while SRAM_DATA_OUT_Pin is valid; the enclosing level uses it as the tristate enable on the shared data bus.
clr_flags  input  1  synchronous clear of counters and sticky flags.
wr_count  output  16  accepted writes, saturating.
rd_count  output  16  accepted reads, saturating.
conflict_flag  output  1  sticky: WR and OE were both low with CS low.
addr_err_flag  output  1  sticky: an access hit an address ≥ 2^DEPTH_LOG2.

Behaviour:
- Reset (RSTn low at a rising edge):
  - All outputs go to 0; read pipeline is flushed.
  - Memory contents are NOT cleared.
  - A read in flight when reset is asserted is discarded; no SRAM_DATA_OE pulse follows.
- Pin sampling: pins are registered once per edge (single-stage input register). The command is decoded from the registered values.
- Command decode, with S = registered pins:
  - IDLE: S.CS high. No action; WR, OE, ADDR and DATA are ignored.
  - WRITE: S.CS low, S.WR low. mem[addr] ← DATA_IN at the decode edge. wr_count increments.
  - READ: S.CS low, S.WR high, S.OE low. Reads mem[addr] at the decode edge and pushes it into a READ_LAT-deep pipeline. rd_count increments.
  - DESELECT-NOP: S.CS low, S.WR high, S.OE high. No action.
- Contention: S.CS, S.WR and S.OE all low → treated as WRITE; no read is issued; conflict_flag is set.
- Address range: only bits above DEPTH_LOG2-1 being nonzero counts as an address error.
  - Out-of-range WRITE: ignored. Memory is unchanged and wr_count still does not increment. addr_err_flag is set.
  - Out-of-range READ: returns all-zero data with normal latency. rd_count increments. addr_err_flag is set.
- Read latency: a read command present on the pins before edge k is decoded at edge k+1. Data and SRAM_DATA_OE appear at edge k+1+READ_LAT and are held for exactly one cycle per command.
- Back-to-back reads: one per cycle; SRAM_DATA_OE stays high continuously.
- Outside valid read slots: SRAM_DATA_OUT_Pin holds its last value; SRAM_DATA_OE is low.
- Ordering hazards:
  - A write to address A followed by a read of A in the next cycle returns the new data.
  - A read of A already in the pipeline returns the value at its decode edge, even if A is written afterwards.
- Counters: 16-bit; saturate at 0xFFFF with no wrap.
- clr_flags:
  - Zeroes wr_count, rd_count, conflict_flag and addr_err_flag at the next edge.
  - If an event occurs in the same cycle, clear wins: the counter ends at 0 and the flag at 0.
  - Does not affect the memory or the read pipeline.

Test Plan:
- Write then read: write 0xDEADBEEF at addr 5 (CS=0, WR=0), then read addr 5 (CS=0, WR=1, OE=0), READ_LAT=2 → OUT=0xDEADBEEF with OE=1 exactly 3 cycles after the read is on the pins; wr_count=1, rd_count=1.
- Burst read: preload addrs 0..3 with 0x10..0x13, issue 4 consecutive reads → SRAM_DATA_OE high for 4 consecutive cycles; data 0x10, 0x11, 0x12, 0x13 in order.
- In-flight read vs write: read addr 7 (holds 0xAA), then write 0x55 to addr 7 the next cycle → the read returns 0xAA; a later read of addr 7 returns 0x55.
- Contention: CS=0, WR=0, OE=0 with data 0x1234 at addr 9 → conflict_flag=1, mem[9]=0x1234, no OE pulse; then clr_flags=1 → flag=0, counters=0.
- Address error (DEPTH_LOG2=10): write to addr 0x400 → memory unchanged, wr_count unchanged, addr_err_flag=1; read of addr 0x400 → OUT=0 with OE pulse after normal latency.
- Reset mid-read: issue a read, assert RSTn=0 on the following edge → no OE pulse; all outputs 0; previously written data is still readable after reset is released.
